cordic_ci_sequencer: RTL and testbench

- Multicycle Nios II custom-instruction front end for the iterative CORDIC cosine datapath.
- Captures the argument on `start`, loads the CORDIC core, and steps it a fixed number of iterations.
- Then feeds the fixed-point cosine through the fixed-to-float converter, registers the float result and pulses `done`.
- Sits between the custom-instruction slot and the shared CORDIC/converter datapath; owns all sequencing.

---
 rtl/cordic_ci_pkg.sv | 8 +
 rtl/cordic_ci_if.sv | 12 +
 rtl/cordic_ci_counter.sv | 20 ++
 rtl/cordic_ci_sequencer.sv | 88 ++++++++
 tb/tb_cordic_ci_sequencer.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/cordic_ci_pkg.sv
// cordic_ci_pkg: shared types and defaults for the CORDIC cosine custom-instruction sequencer
package cordic_ci_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, ITER, CVT, DONE} state_t;
    localparam int DEF_N_ITER  = 16;
    localparam int DEF_CVT_LAT = 1;
    localparam int ITER_W      = 5;
    localparam int CVT_W       = 3;
endpackage

// File: rtl/cordic_ci_if.sv
// cordic_ci_if: Nios II custom-instruction slot signals
//   clk_en, start, dataa : host -> sequencer
//   result, done         : sequencer -> host
interface cordic_ci_if #(parameter int W = 32);
    logic         clk_en;
    logic         start;
    logic [W-1:0] dataa;
    logic [W-1:0] result;
    logic         done;
    modport master (output clk_en, start, dataa, input result, done);
    modport slave  (input clk_en, start, dataa, output result, done);
endinterface

// File: rtl/cordic_ci_counter.sv
// cordic_ci_counter: loadable up-counter with terminal-count flag
//   clock, reset (sync, active-low), en : clock enable
//   load  : clear count to 0 (otherwise counts up while en)
//   count : current value; tc : count == LAST
module cordic_ci_counter #(
    parameter int W    = 5,
    parameter int LAST = 0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    input  logic         load,
    output logic [W-1:0] count,
    output logic         tc
);
    always_ff @(posedge clock)
        if (!reset) count <= '0;
        else if (en) count <= load ? '0 : count + 1'b1;
    assign tc = count == W'(LAST);
endmodule

// File: rtl/cordic_ci_sequencer.sv
// cordic_ci_sequencer: multicycle custom-instruction front end for the iterative CORDIC cosine datapath
//   clock, reset (sync, active-low)
//   ci        : custom-instruction slot (clk_en, start, dataa, result, done)
//   dp_*      : CORDIC core control (angle, load/step strobes, iteration index) and cosine return
//   cvt_*     : fixed-to-float converter input and output
//   Optional CORDIC_CI_CACHE_EN: repeat of the last completed argument finishes in one edge.
module cordic_ci_sequencer
    import cordic_ci_pkg::*;
#(
    parameter int W       = 32,
    parameter int N_ITER  = DEF_N_ITER,
    parameter int CVT_LAT = DEF_CVT_LAT
) (
    input  logic              clock,
    input  logic              reset,
    cordic_ci_if.slave        ci,
    output logic [W-1:0]      dp_angle,
    output logic              dp_load,
    output logic              dp_step,
    output logic [ITER_W-1:0] dp_iter,
    input  logic [W-1:0]      dp_cos,
    output logic [W-1:0]      cvt_fixed,
    input  logic [W-1:0]      cvt_float
);
    state_t state, state_nxt;
    logic [ITER_W-1:0] iter_cnt;
    logic iter_tc, cvt_tc, hit, fin;

    // Counters are held at zero outside their own state, so each run starts fresh
    cordic_ci_counter #(.W(ITER_W), .LAST(N_ITER - 1)) u_iter (
        .clock(clock), .reset(reset), .en(ci.clk_en), .load(state != ITER),
        .count(iter_cnt), .tc(iter_tc)
    );
    cordic_ci_counter #(.W(CVT_W), .LAST(CVT_LAT - 1)) u_cvt (
        .clock(clock), .reset(reset), .en(ci.clk_en), .load(state != CVT),
        .count(), .tc(cvt_tc)
    );

    assign fin = state == CVT && cvt_tc;

`ifdef CORDIC_CI_CACHE_EN
    logic [W-1:0] cache_arg;
    logic         cache_vld;
    assign hit = cache_vld && ci.dataa == cache_arg;
    always_ff @(posedge clock)
        if (!reset) begin
            cache_arg <= '0;
            cache_vld <= 1'b0;
        end else if (ci.clk_en && fin) begin
            cache_arg <= dp_angle;
            cache_vld <= 1'b1;
        end
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge clock)
        if (!reset) state <= IDLE;
        else if (ci.clk_en) state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = ci.start ? (hit ? DONE : LOAD) : IDLE;
            LOAD:    state_nxt = ITER;
            ITER:    state_nxt = iter_tc ? CVT : ITER;
            CVT:     state_nxt = cvt_tc ? DONE : CVT;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        dp_load = state == LOAD;
        dp_step = state == ITER;
        dp_iter = dp_step ? iter_cnt : '0;
    end

    always_ff @(posedge clock)
        if (!reset) begin
            dp_angle  <= '0;
            cvt_fixed <= '0;
            ci.result <= '0;
            ci.done   <= 1'b0;
        end else if (ci.clk_en) begin
            if (state == IDLE && ci.start && !hit) dp_angle <= ci.dataa;
            if (state == ITER && iter_tc) cvt_fixed <= dp_cos;
            if (fin) ci.result <= cvt_float;
            ci.done <= fin || (state == IDLE && ci.start && hit);
        end
endmodule

// File: tb/tb_cordic_ci_sequencer.sv
// tb_cordic_ci_sequencer: directed self-checking bench for cordic_ci_sequencer
module tb_cordic_ci_sequencer;
    import cordic_ci_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] dp_angle, dp_cos, cvt_fixed, cvt_float;
    logic        dp_load, dp_step;
    logic [4:0]  dp_iter;
    int          tests = 0, fails = 0;
    int          n_load = 0, n_step = 0, n_done = 0;
    logic        done_q = 1'b0;
    logic [4:0]  iter_log[$];

    cordic_ci_if #(.W(32)) ci ();

    cordic_ci_sequencer dut (
        .clock(clock), .reset(reset), .ci(ci),
        .dp_angle(dp_angle), .dp_load(dp_load), .dp_step(dp_step), .dp_iter(dp_iter),
        .dp_cos(dp_cos), .cvt_fixed(cvt_fixed), .cvt_float(cvt_float)
    );

    // Stubs: cosine = 0x4000_0000 + angle; float = 0x3F80_0000 + (fixed - 0x4000_0000)
    assign dp_cos    = 32'h4000_0000 + dp_angle;
    assign cvt_float = cvt_fixed - 32'h4000_0000 + 32'h3F80_0000;

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (ci.clk_en && reset) begin
            if (dp_load) n_load++;
            if (dp_step) begin
                iter_log.push_back(dp_iter);
                n_step++;
            end
        end
        if (ci.done && !done_q) n_done++;
        done_q = ci.done;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic run(input logic [31:0] a, input int busy_at, input int stall_at, output int lat);
        ci.dataa = a;
        ci.start = 1'b1;
        lat = 0;
        while (!ci.done && lat < 60) begin
            tick;
            lat++;
            ci.start = lat == busy_at;
            if (lat == busy_at) ci.dataa = 32'h1234_5678;
            ci.clk_en = !(lat >= stall_at && lat < stall_at + 5);
            if (lat == stall_at + 4) check("stall_iter_frozen", 32'(dp_iter), 32'd6);
        end
        ci.start  = 1'b0;
        ci.clk_en = 1'b1;
    endtask

    initial begin
        int lat, l0, s0, d0, b0;
        reset = 1'b0;
        ci.clk_en = 1'b1;
        ci.start = 1'b1;
        ci.dataa = 32'hAAAA_5555;
        repeat (3) tick;
        check("rst_result", ci.result, 32'h0);
        check("rst_done", 32'(ci.done), 32'h0);
        check("rst_load", 32'(dp_load), 32'h0);
        check("rst_step", 32'(dp_step), 32'h0);
        check("rst_angle", dp_angle, 32'h0);
        check("rst_cvt", cvt_fixed, 32'h0);
        reset = 1'b1;
        ci.start = 1'b0;
        tick;
        check("rst_idle_load", 32'(dp_load), 32'h0);
        check("rst_nload", 32'(n_load), 32'd0);

        l0 = n_load; s0 = n_step; b0 = iter_log.size();
        run(32'h0, 0, 100, lat);
        check("nom_latency", 32'(lat), 32'd19);
        check("nom_result", ci.result, 32'h3F80_0000);
        check("nom_loads", 32'(n_load - l0), 32'd1);
        check("nom_steps", 32'(n_step - s0), 32'd16);
        for (int i = 0; i < 16; i++)
            if (b0 + i < iter_log.size()) check($sformatf("nom_iter%0d", i), 32'(iter_log[b0 + i]), 32'(i));
        tick;
        check("nom_done_clear", 32'(ci.done), 32'h0);

        l0 = n_load; d0 = n_done;
        run(32'h10, 5, 100, lat);
        check("busy_latency", 32'(lat), 32'd19);
        check("busy_angle", dp_angle, 32'h10);
        check("busy_result", ci.result, 32'h3F80_0010);
        repeat (3) tick;
        check("busy_loads", 32'(n_load - l0), 32'd1);
        check("busy_dones", 32'(n_done - d0), 32'd1);

        s0 = n_step;
        run(32'h3, 0, 8, lat);
        check("stall_latency", 32'(lat), 32'd24);
        check("stall_steps", 32'(n_step - s0), 32'd16);
        check("stall_result", ci.result, 32'h3F80_0003);
        ci.clk_en = 1'b0;
        repeat (3) tick;
        check("hold_done", 32'(ci.done), 32'h1);
        ci.clk_en = 1'b1;
        tick;
        check("hold_done_clear", 32'(ci.done), 32'h0);

        ci.dataa = 32'h7;
        ci.start = 1'b1;
        tick;
        ci.start = 1'b0;
        repeat (8) tick;
        check("mid_iter7", 32'(dp_iter), 32'd7);
        reset = 1'b0;
        tick;
        check("mid_step", 32'(dp_step), 32'h0);
        check("mid_iter", 32'(dp_iter), 32'h0);
        check("mid_result", ci.result, 32'h0);
        check("mid_angle", dp_angle, 32'h0);
        reset = 1'b1;
        d0 = n_done;
        repeat (30) tick;
        check("mid_no_done", 32'(n_done - d0), 32'd0);
        check("mid_no_load", 32'(dp_load), 32'h0);

        run(32'h5, 0, 100, lat);
        check("c1_latency", 32'(lat), 32'd19);
        check("c1_result", ci.result, 32'h3F80_0005);
        tick;
        s0 = n_step;
        run(32'h5, 0, 100, lat);
`ifdef CORDIC_CI_CACHE_EN
        check("c2_latency", 32'(lat), 32'd1);
        check("c2_steps", 32'(n_step - s0), 32'd0);
`else
        check("c2_latency", 32'(lat), 32'd19);
        check("c2_steps", 32'(n_step - s0), 32'd16);
`endif
        check("c2_result", ci.result, 32'h3F80_0005);
        tick;
        run(32'h6, 0, 100, lat);
        check("c3_latency", 32'(lat), 32'd19);
        check("c3_result", ci.result, 32'h3F80_0006);
        tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
